// File: rtl/class_score_scheduler_if.sv
// Bus bundle between the class score scheduler, the per-class counter bank,
// the shared score adder and the inference result consumer.
interface class_score_scheduler_if #(
  parameter int CLS_W = 4
);
  logic             start;
  logic             busy;
  logic             cnt_rd_en;
  logic [CLS_W-1:0] cnt_rd_addr;
  logic [103:0]     cnt_rd_data;
  logic [103:0]     adder_val;
  logic [7:0]       adder_score;
  logic             score_strobe;
  logic [CLS_W-1:0] score_class;
  logic [7:0]       score_out;
  logic             result_valid;
  logic             result_ready;
  logic [CLS_W-1:0] result_digit;
  logic [7:0]       result_score;

  modport master (
    input  start, cnt_rd_data, adder_score, result_ready,
    output busy, cnt_rd_en, cnt_rd_addr, adder_val,
           score_strobe, score_class, score_out,
           result_valid, result_digit, result_score
  );

  modport slave (
    output start, cnt_rd_data, adder_score, result_ready,
    input  busy, cnt_rd_en, cnt_rd_addr, adder_val,
           score_strobe, score_class, score_out,
           result_valid, result_digit, result_score
  );
endinterface

// File: rtl/class_score_scheduler.sv
// Streams every class's counter bank through one shared score adder, tracks the
// running argmax and hands the winning digit/score out over valid/ready.
module class_score_scheduler #(
  parameter int NUM_CLASSES = 10,
  parameter int CLS_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  class_score_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CLS_W-1:0] LAST_CLASS = CLS_W'(NUM_CLASSES - 1);

  state_t           state, state_nx;

  logic             issue_en;
  logic [CLS_W-1:0] issue_idx;
  logic             cmp_valid;
  logic [CLS_W-1:0] cmp_class;
  logic             cmp_last;

  logic [CLS_W-1:0] best_class, best_class_nx;
  logic [7:0]       best_score, best_score_nx;
  logic             cmp_win;

  logic             score_strobe_q;
  logic [CLS_W-1:0] score_class_q;
  logic [7:0]       score_out_q;
  logic             result_valid_q;
  logic [CLS_W-1:0] result_digit_q;
  logic [7:0]       result_score_q;

  assign cmp_last = cmp_valid && (cmp_class == LAST_CLASS);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start)                             state_nx = RUN;
      RUN:     if (cmp_last)                              state_nx = DONE;
      DONE:    if (result_valid_q && bus.result_ready)    state_nx = IDLE;
      default:                                            state_nx = IDLE;
    endcase
  end

  // Class 0 always seeds the running best, so nothing stale survives from a
  // previous inference; later classes need a strictly greater score to win.
  always_comb begin
    cmp_win       = (cmp_class == '0) || (bus.adder_score > best_score);
    best_class_nx = best_class;
    best_score_nx = best_score;
    if (cmp_valid && cmp_win) begin
      best_class_nx = cmp_class;
      best_score_nx = bus.adder_score;
    end
  end

  // Issue/compare pipeline, running best and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_en       <= 1'b0;
      issue_idx      <= '0;
      cmp_valid      <= 1'b0;
      cmp_class      <= '0;
      best_class     <= '0;
      best_score     <= '0;
      score_strobe_q <= 1'b0;
      score_class_q  <= '0;
      score_out_q    <= '0;
      result_valid_q <= 1'b0;
      result_digit_q <= '0;
      result_score_q <= '0;
    end else begin
      score_strobe_q <= cmp_valid;
      if (cmp_valid) begin
        score_class_q <= cmp_class;
        score_out_q   <= bus.adder_score;
      end
      best_class <= best_class_nx;
      best_score <= best_score_nx;

      unique case (state)
        IDLE: begin
          cmp_valid <= 1'b0;
          if (bus.start) begin
            issue_en  <= 1'b1;
            issue_idx <= '0;
          end
        end
        RUN: begin
          cmp_valid <= issue_en;
          cmp_class <= issue_idx;
          if (issue_en) begin
            // Index returns to 0 after the last issue so the address bus idles low.
            if (issue_idx == LAST_CLASS) begin
              issue_en  <= 1'b0;
              issue_idx <= '0;
            end else begin
              issue_idx <= issue_idx + CLS_W'(1);
            end
          end
          if (cmp_last) begin
            result_valid_q <= 1'b1;
            result_digit_q <= best_class_nx;
            result_score_q <= best_score_nx;
          end
        end
        DONE: begin
          cmp_valid <= 1'b0;
          if (result_valid_q && bus.result_ready) result_valid_q <= 1'b0;
        end
        default: begin
          cmp_valid <= 1'b0;
          issue_en  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.cnt_rd_en    = issue_en;
  assign bus.cnt_rd_addr  = issue_idx;
  assign bus.adder_val    = cmp_valid ? bus.cnt_rd_data : '0;
  assign bus.score_strobe = score_strobe_q;
  assign bus.score_class  = score_class_q;
  assign bus.score_out    = score_out_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_digit = result_digit_q;
  assign bus.result_score = result_score_q;

endmodule

// File: tb/tb_class_score_scheduler.sv
// Bench for class_score_scheduler: counter bank and shared adder models plus a
// reference argmax computed from the bank contents.
module tb_class_score_scheduler;

  localparam int NUM   = 10;
  localparam int CLS_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  class_score_scheduler_if #(.CLS_W(CLS_W)) bus ();

  class_score_scheduler #(
    .NUM_CLASSES(NUM),
    .CLS_W      (CLS_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [103:0] bank [NUM];
  logic [7:0]   exp_sc [NUM];
  logic [7:0]   exp_score;
  int           exp_digit;
  int           checks = 0;
  int           errors = 0;

  // Counter bank: one-cycle read latency
  always @(posedge clk) begin
    if (!rst_n)             bus.cnt_rd_data <= '0;
    else if (bus.cnt_rd_en) bus.cnt_rd_data <= bank[bus.cnt_rd_addr];
  end

  // Shared adder: 128 + 8*val[12], other counters contribute nothing
  assign bus.adder_score = 8'd128 + {bus.adder_val[100:96], 3'b000};

  task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_class(input int c, input int v12);
    bank[c] = {8'(v12), $urandom(), $urandom(), $urandom()};
  endtask

  // Reference: every score from the spec formula, then the lowest index among
  // the classes holding the maximum.
  task automatic model();
    int m;
    m = 0;
    for (int c = 0; c < NUM; c++) begin
      exp_sc[c] = 8'(128 + 8 * int'(bank[c][103:96]));
      if (int'(exp_sc[c]) > m) m = int'(exp_sc[c]);
    end
    exp_digit = -1;
    for (int c = NUM - 1; c >= 0; c--)
      if (int'(exp_sc[c]) == m) exp_digit = c;
    exp_score = 8'(m);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},    bus.busy,         0);
    chk({tag, "_rd_en"},   bus.cnt_rd_en,    0);
    chk({tag, "_rd_addr"}, bus.cnt_rd_addr,  0);
    chk({tag, "_adder"},   bus.adder_val,    0);
    chk({tag, "_strobe"},  bus.score_strobe, 0);
    chk({tag, "_sclass"},  bus.score_class,  0);
    chk({tag, "_sout"},    bus.score_out,    0);
    chk({tag, "_valid"},   bus.result_valid, 0);
    chk({tag, "_digit"},   bus.result_digit, 0);
    chk({tag, "_score"},   bus.result_score, 0);
  endtask

  task automatic load_nominal();
    for (int c = 0; c < NUM; c++) set_class(c, c);
    set_class(3, 12);
  endtask

  // One inference; cycle k is the k-th cycle after the start edge.
  task automatic run_inference(input string tag, input int ready_delay, input bit poke_start);
    int last_cyc;
    model();
    last_cyc = NUM + 2 + ready_delay;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      if (cyc > 1) @(negedge clk);
      chk({tag, "_busy"},  bus.busy,      1);
      chk({tag, "_rd_en"}, bus.cnt_rd_en, (cyc <= NUM) ? 1 : 0);
      if (cyc <= NUM) chk({tag, "_rd_addr"}, bus.cnt_rd_addr, cyc - 1);
      if (cyc >= 2 && cyc <= NUM + 1) chk({tag, "_adder"}, bus.adder_val, bank[cyc-2]);
      else                            chk({tag, "_adder_idle"}, bus.adder_val, 0);
      chk({tag, "_strobe"}, bus.score_strobe, (cyc >= 3 && cyc <= NUM + 2) ? 1 : 0);
      if (cyc >= 3 && cyc <= NUM + 2) begin
        chk({tag, "_sclass"}, bus.score_class, cyc - 3);
        chk({tag, "_sout"},   bus.score_out,   exp_sc[cyc-3]);
      end
      chk({tag, "_valid"}, bus.result_valid, (cyc >= NUM + 2) ? 1 : 0);
      if (cyc >= NUM + 2) begin
        chk({tag, "_digit"}, bus.result_digit, exp_digit);
        chk({tag, "_score"}, bus.result_score, exp_score);
      end
      bus.start = poke_start && (cyc == 4 || cyc == NUM + 3);
    end
    bus.result_ready = 1'b1;
    bus.start        = poke_start;
    @(negedge clk);
    bus.result_ready = 1'b0;
    bus.start        = 1'b0;
    chk({tag, "_hs_valid"},  bus.result_valid, 0);
    chk({tag, "_hs_busy"},   bus.busy,         0);
    chk({tag, "_hs_strobe"}, bus.score_strobe, 0);
    chk({tag, "_hs_digit"},  bus.result_digit, exp_digit);
    chk({tag, "_hs_score"},  bus.result_score, exp_score);
    @(negedge clk);
    chk({tag, "_idle_busy"},  bus.busy,      0);
    chk({tag, "_idle_rd_en"}, bus.cnt_rd_en, 0);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    for (int c = 0; c < NUM; c++) bank[c] = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    load_nominal();
    run_inference("nominal", 0, 1'b0);
    chk("nominal_digit_is_3", 104'(exp_digit), 3);
    chk("nominal_score_is_224", 104'(exp_score), 224);

    for (int c = 0; c < NUM; c++) set_class(c, 0);
    run_inference("all_zero", 0, 1'b0);

    for (int c = 0; c < NUM; c++) set_class(c, 0);
    set_class(4, 5);
    set_class(7, 5);
    run_inference("tie", 0, 1'b0);

    load_nominal();
    run_inference("backpressure", 5, 1'b1);

    load_nominal();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    run_inference("after_rst", 0, 1'b0);

    load_nominal();
    run_inference("b2b_first", 0, 1'b0);
    for (int c = 0; c < NUM - 1; c++) set_class(c, int'($urandom_range(0, 14)));
    set_class(9, 15);
    run_inference("b2b_second", 1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      for (int c = 0; c < NUM; c++) set_class(c, int'($urandom_range(0, 31)));
      if (t % 4 == 0) set_class(int'($urandom_range(1, NUM - 1)), int'(bank[0][103:96]));
      run_inference("random", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/class_score_scheduler.md
Name: class_score_scheduler

Overview:
- Time-multiplexes one shared score adder across all digit classes for a single inference.
- On `start`, reads each class's 13-entry counter bank in turn and presents it to the shared adder.
- Registers each returned score and tracks the running argmax.
- Delivers the predicted digit and its score over a valid/ready handshake.
- Sits between the per-class counter bank memory and the inference result interface.

Parameters:
- NUM_CLASSES, 10, number of classes scored per inference (≥2)
- CLS_W, 4, width of class index; must satisfy 2^CLS_W ≥ NUM_CLASSES

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start  in  1  begin scoring; honoured only in IDLE
- busy  out  1  high in RUN and DONE
- cnt_rd_en  out  1  counter bank read enable
- cnt_rd_addr  out  CLS_W  class index being read
- cnt_rd_data  in  104  13 counters, val[i] at bits [8i+7:8i]; valid the cycle after the read is issued
- adder_val  out  104  same packing, drives shared adder inputs
- adder_score  in  8  shared adder result; combinational from adder_val; base 0.25 units, 128 = zero
- score_strobe  out  1  one-cycle pulse per scored class
- score_class  out  CLS_W  class of the current strobe
- score_out  out  8  score of the current strobe
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_digit  out  CLS_W  argmax class
- result_score  out  8  max score

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-low (`rst_n`), sampled on the rising edge of `clk`.
  - Reset forces state IDLE and clears all registered outputs and internal counters to 0.
  - Reset applied mid-run abandons the inference; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `busy`=0, `cnt_rd_en`=0.
  - On an edge with `start`=1: load issue index 0, clear the compare-stage valid bit, go to RUN.
- RUN, issue stage:
  - `cnt_rd_en`=1 and `cnt_rd_addr`=issue index for exactly NUM_CLASSES consecutive cycles (0,1,…,NUM_CLASSES-1).
  - After the last address is issued, `cnt_rd_en`=0.
- RUN, compare stage:
  - One cycle after each read issue, the registered `cmp_valid` and `cmp_class` are set.
  - In that cycle `adder_val` = `cnt_rd_data`. In every other cycle `adder_val` = 0, so the shared adder is quiescent.
  - At the edge ending a `cmp_valid` cycle:
    - `score_strobe`=1 next cycle, with `score_class`=`cmp_class` and `score_out`=`adder_score`.
    - If `cmp_class`==0, load best = (0, `adder_score`) unconditionally.
    - Otherwise update best only if `adder_score` > best_score, unsigned and strict. Ties keep the lower class index.
- RUN to DONE:
  - At the edge that compares class NUM_CLASSES-1: go to DONE, set `result_valid`=1, and load `result_digit`/`result_score` from the best value including that last comparison.
  - Latency: `result_valid` rises NUM_CLASSES+1 edges after the start edge (11 for the default).
- DONE:
  - `result_*` held stable while `result_valid`=1 and `result_ready`=0.
  - On an edge with `result_valid`&`result_ready`: clear `result_valid`, go to IDLE. `result_digit`/`result_score` keep their values until the next inference loads them.
  - `start` asserted in the same cycle as that handshake is ignored; a new start is accepted only from IDLE on a later edge.
- `start` asserted in RUN or DONE has no effect; it is not queued.
- `score_strobe` is never high in IDLE or DONE, except for the pulse on the first DONE cycle (for class NUM_CLASSES-1).
- No arithmetic is performed beyond the 8-bit unsigned compare; scores are not saturated or modified.

Test Plan:
- Bench: counter bank model with 1-cycle read latency; shared adder model computes `score` = 128 + 8·val[12] with all other counters 0.
- Nominal: class c has val[12]=c, except class 3 with val[12]=12 → `score_strobe` sequence 128,136,…; class 3 = 224; `result_digit`=3, `result_score`=224; `result_valid` exactly 11 cycles after start edge.
- Address timing: `cnt_rd_addr` = 0..9 on 10 consecutive cycles with `cnt_rd_en`=1, then `cnt_rd_en`=0; `adder_val`=0 outside compare cycles.
- Tie/zero: all counters 0 → every score 128; `result_digit`=0, `result_score`=128. Classes 4 and 7 both val[12]=5 → `result_digit`=4, `result_score`=168.
- Backpressure: `result_ready` low for 5 cycles after `result_valid`, with `start` pulsed in RUN and DONE → outputs stable, no new reads, `busy`=1; `result_ready` high → IDLE next cycle; next start runs a fresh inference.
- Reset mid-run: `rst_n` low on cycle 5 of RUN → next cycle all outputs 0, state IDLE; subsequent start gives the correct nominal result.
- Back-to-back: handshake then start two cycles later, second bank has argmax 9 (val[12]=15) → `result_digit`=9, `result_score`=248; no stale best carried over.
